// File: rtl/moto_key_ctrl.sv
// moto_key_ctrl
// Command stage ahead of the PWM motor driver. Raw active-low board keys are
// synchronised, debounced per bit, and passed to the PWM stage as a registered
// active-low key vector. A direction change while the motor runs is delayed
// behind a motor-off dead time so the bridge never reverses under drive.
// Key encoding (0 = pressed/active): bit0 enable, bit1 direction,
// bit2 speed0, bit3 speed1.

module moto_key_ctrl #(
   parameter int DB_CYCLES   = 500000,  // stable cycles needed to accept a key change
   parameter int DB_W        = 20,      // debounce counter width, holds DB_CYCLES-1
   parameter int DEAD_CYCLES = 50000,   // motor-off cycles on a reversal
   parameter int DEAD_W      = 16       // dead-time counter width, holds DEAD_CYCLES-1
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic [3:0] key_raw,
   output logic [3:0] key_db,
   output logic [3:0] key_out,
   output logic       moto_run,
   output logic       dead_busy
);

   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
   localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DEAD = 2'd2
   } state_t;

   // ------------------------------------------------------------------
   // Synchroniser
   // ------------------------------------------------------------------
   logic [3:0] key_meta;
   logic [3:0] key_sync;

   // Two-flop synchroniser per key; idles released (1) out of reset.
   // NOTE: sequential state always uses non-blocking (<=) so every flop
   // samples the pre-edge value of its neighbours; blocking here would
   // collapse the two stages into one.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         key_meta <= 4'b1111;
         key_sync <= 4'b1111;
      end else begin
         key_meta <= key_raw;
         key_sync <= key_meta;
      end
   end

   // ------------------------------------------------------------------
   // Debounce: one counter per key, counting consecutive mismatch cycles
   // ------------------------------------------------------------------
   logic [DB_W-1:0] db_cnt [4];

   // Accept a key change only after DB_CYCLES consecutive disagreeing cycles.
   // NOTE: the counter array is only four words of flops, so it is reset
   // like any other register; a large RAM-style memory would not be.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         key_db <= 4'b1111;
         for (int i = 0; i < 4; i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (key_sync[i] != key_db[i]) begin
               if (db_cnt[i] == DB_LAST) begin
                  key_db[i] <= key_sync[i];
                  db_cnt[i] <= '0;
               end else begin
                  db_cnt[i] <= db_cnt[i] + 1'b1;
               end
            end else begin
               db_cnt[i] <= '0;
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Run / dead-time FSM
   // ------------------------------------------------------------------
   state_t            state;
   state_t            state_nxt;
   logic              dir_applied;
   logic              dir_nxt;
   logic [DEAD_W-1:0] dead_cnt;
   logic [DEAD_W-1:0] dead_cnt_nxt;
   logic [3:0]        key_out_nxt;
   logic              en;

   assign en = ~key_db[0];

   // Next state, applied direction and dead-time count from debounced keys.
   // NOTE: every signal driven here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_nxt    = state;
      dir_nxt      = dir_applied;
      dead_cnt_nxt = dead_cnt;

      unique case (state)
         ST_IDLE: begin
            // Motor stopped: direction tracks the key freely, no dead time.
            dir_nxt      = key_db[1];
            dead_cnt_nxt = '0;
            if (en) begin
               state_nxt = ST_RUN;
            end
         end

         ST_RUN: begin
            // Dropping enable wins over a simultaneous reversal; the new
            // direction is then picked up in IDLE.
            if (!en) begin
               state_nxt = ST_IDLE;
            end else if (key_db[1] != dir_applied) begin
               state_nxt    = ST_DEAD;
               dead_cnt_nxt = '0;
            end
         end

         ST_DEAD: begin
            // The full dead time always runs, whatever the keys do meanwhile.
            if (dead_cnt == DEAD_LAST) begin
               dir_nxt      = key_db[1];
               dead_cnt_nxt = '0;
               state_nxt    = en ? ST_RUN : ST_IDLE;
            end else begin
               dead_cnt_nxt = dead_cnt + 1'b1;
            end
         end

         default: begin
            state_nxt    = ST_IDLE;
            dead_cnt_nxt = '0;
         end
      endcase
   end

   // Output vector as it should look after this edge: enable is asserted
   // only in RUN, direction is whatever will be applied after the edge.
   always_comb begin
      key_out_nxt = {key_db[3:2], dir_nxt, (state_nxt == ST_RUN) ? 1'b0 : 1'b1};
   end

   // State, direction, counter and registered outputs update together.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state       <= ST_IDLE;
         dir_applied <= 1'b1;
         dead_cnt    <= '0;
         key_out     <= 4'b1111;
         moto_run    <= 1'b0;
         dead_busy   <= 1'b0;
      end else begin
         state       <= state_nxt;
         dir_applied <= dir_nxt;
         dead_cnt    <= dead_cnt_nxt;
         key_out     <= key_out_nxt;
         moto_run    <= (state_nxt == ST_RUN);
         dead_busy   <= (state_nxt == ST_DEAD);
      end
   end

endmodule
